// File: rtl/eth_link_failover.sv
// Dual-PHY link failover controller: synchronises and debounces both link inputs,
// then selects a port through a guarded switchover FSM with optional manual override.
module eth_link_failover #(
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int BLINK_DIV   = 8,
  parameter bit REVERT      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link1,
  input  logic       link2,
  input  logic       force_en,
  input  logic       force_sel,
  output logic       sel,
  output logic       mux_en,
  output logic       led_act,
  output logic [7:0] switch_cnt
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  typedef enum logic [1:0] {
    NOLINK  = 2'd0,
    ACTIVE1 = 2'd1,
    ACTIVE2 = 2'd2,
    GUARD   = 2'd3
  } state_t;

  state_t state, state_n;
  logic   target, target_n;
  logic   enter_guard;

  logic [1:0]        link_p0, link_p1;
  logic [1:0]        deb;
  logic [DEB_W-1:0]  deb_cnt [2];
  logic [HOLD_W-1:0] guard_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic              led_blink;
  logic              deb1, deb2, guard_done;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchronisers for the raw link inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_p0 <= '0;
      link_p1 <= '0;
    end else begin
      link_p0 <= {link2, link1};
      link_p1 <= link_p0;
    end
  end

  // Debounce: a new level is accepted only after DEB_CYCLES unbroken cycles of disagreement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb        <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (link_p1[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
            deb[i]     <= link_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign deb1       = deb[0];
  assign deb2       = deb[1];
  assign guard_done = (guard_cnt == HOLD_W'(HOLD_CYCLES - 1));

  always_comb begin
    state_n     = state;
    target_n    = target;
    enter_guard = 1'b0;
    unique case (state)
      NOLINK: begin
        if (force_en) begin
          enter_guard = 1'b1;
          target_n    = force_sel;
        end else if (deb1) begin
          enter_guard = 1'b1;
          target_n    = 1'b1;
        end else if (deb2) begin
          enter_guard = 1'b1;
          target_n    = 1'b0;
        end
      end
      ACTIVE1: begin
        if (force_en) begin
          if (!force_sel) begin
            enter_guard = 1'b1;
            target_n    = 1'b0;
          end
        end else if (!deb1 && deb2) begin
          enter_guard = 1'b1;
          target_n    = 1'b0;
        end else if (!deb1 && !deb2) begin
          state_n = NOLINK;
        end
      end
      ACTIVE2: begin
        if (force_en) begin
          if (force_sel) begin
            enter_guard = 1'b1;
            target_n    = 1'b1;
          end
        end else if (!deb1 && !deb2) begin
          state_n = NOLINK;
        end else if (deb1 && (REVERT || !deb2)) begin
          enter_guard = 1'b1;
          target_n    = 1'b1;
        end
      end
      GUARD: begin
        // Link activity is ignored until expiry; only a forced retarget restarts the guard
        if (force_en && (force_sel != target)) begin
          enter_guard = 1'b1;
          target_n    = force_sel;
        end else if (guard_done) begin
          if (force_en || (target ? deb1 : deb2)) begin
            state_n = target ? ACTIVE1 : ACTIVE2;
          end else if (target ? deb2 : deb1) begin
            enter_guard = 1'b1;
            target_n    = !target;
          end else begin
            state_n = NOLINK;
          end
        end
      end
      default: state_n = NOLINK;
    endcase
    if (enter_guard) begin
      state_n = GUARD;
    end
  end

  // Stage state: FSM, guard timer, switch counter and blink generator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NOLINK;
      target     <= 1'b1;
      guard_cnt  <= '0;
      switch_cnt <= '0;
      blink_cnt  <= '0;
      led_blink  <= 1'b0;
    end else begin
      state  <= state_n;
      target <= target_n;
      if (enter_guard) begin
        guard_cnt  <= '0;
        switch_cnt <= sat_inc(switch_cnt);
      end else if (state == GUARD) begin
        guard_cnt <= guard_cnt + 1'b1;
      end else begin
        guard_cnt <= '0;
      end
      if (state_n == ACTIVE2 && state != ACTIVE2) begin
        blink_cnt <= '0;
        led_blink <= 1'b1;
      end else if (state == ACTIVE2) begin
        if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          led_blink <= !led_blink;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        led_blink <= 1'b0;
      end
    end
  end

  // Outputs decoded straight from registered state
  always_comb begin
    sel     = 1'b1;
    mux_en  = 1'b0;
    led_act = 1'b0;
    unique case (state)
      NOLINK:  sel = 1'b1;
      ACTIVE1: begin
        sel     = 1'b1;
        mux_en  = 1'b1;
        led_act = 1'b1;
      end
      ACTIVE2: begin
        sel     = 1'b0;
        mux_en  = 1'b1;
        led_act = led_blink;
      end
      GUARD:   sel = target;
      default: sel = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_eth_link_failover.sv
// Directed vector bench for eth_link_failover using default parameters.
module tb_eth_link_failover;

  logic       clk = 1'b0;
  logic       rst;
  logic       link1, link2, force_en, force_sel;
  logic       sel, mux_en, led_act;
  logic [7:0] switch_cnt;

  int errors = 0;
  int checks = 0;

  eth_link_failover dut (
    .clk        (clk),
    .rst        (rst),
    .link1      (link1),
    .link2      (link2),
    .force_en   (force_en),
    .force_sel  (force_sel),
    .sel        (sel),
    .mux_en     (mux_en),
    .led_act    (led_act),
    .switch_cnt (switch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        l1;
    logic        l2;
    logic        fe;
    logic        fs;
    int unsigned n;
    logic        e_sel;
    logic        e_mux;
    logic        e_led;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic es, input logic em,
                         input logic el, input logic [7:0] ec);
    chk({tag, ".sel"}, int'(sel), int'(es));
    chk({tag, ".mux_en"}, int'(mux_en), int'(em));
    chk({tag, ".led_act"}, int'(led_act), int'(el));
    chk({tag, ".switch_cnt"}, int'(switch_cnt), int'(ec));
  endtask

  function automatic vec_t mk(input logic l1, input logic l2, input logic fe, input logic fs,
                              input int unsigned n, input logic es, input logic em,
                              input logic el, input logic [7:0] ec);
    vec_t v;
    v.l1 = l1; v.l2 = l2; v.fe = fe; v.fs = fs; v.n = n;
    v.e_sel = es; v.e_mux = em; v.e_led = el; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    // Bring-up on port 1, debounce latency and 64-cycle guard
    vecs.push_back(mk(1,0,0,0, 18, 1,0,0, 0));
    vecs.push_back(mk(1,0,0,0,  1, 1,0,0, 1));
    vecs.push_back(mk(1,0,0,0, 63, 1,0,0, 1));
    vecs.push_back(mk(1,0,0,0,  1, 1,1,1, 1));
    // Short glitch on link1 is filtered
    vecs.push_back(mk(0,0,0,0, 10, 1,1,1, 1));
    vecs.push_back(mk(1,0,0,0, 30, 1,1,1, 1));
    // Failover to port 2 and blink pattern
    vecs.push_back(mk(0,1,0,0, 18, 1,1,1, 1));
    vecs.push_back(mk(0,1,0,0,  1, 0,0,0, 2));
    vecs.push_back(mk(0,1,0,0, 63, 0,0,0, 2));
    vecs.push_back(mk(0,1,0,0,  1, 0,1,1, 2));
    vecs.push_back(mk(0,1,0,0,  7, 0,1,1, 2));
    vecs.push_back(mk(0,1,0,0,  1, 0,1,0, 2));
    vecs.push_back(mk(0,1,0,0,  7, 0,1,0, 2));
    vecs.push_back(mk(0,1,0,0,  1, 0,1,1, 2));
    // Revert to port 1, both links lost mid-guard
    vecs.push_back(mk(1,1,0,0, 19, 1,0,0, 3));
    vecs.push_back(mk(0,0,0,0, 40, 1,0,0, 3));
    vecs.push_back(mk(0,0,0,0, 23, 1,0,0, 3));
    vecs.push_back(mk(0,0,0,0,  1, 1,0,0, 3));
    vecs.push_back(mk(0,0,0,0,100, 1,0,0, 3));
    // Forced switch to a dead port 2, release reverts
    vecs.push_back(mk(1,0,0,0, 19, 1,0,0, 4));
    vecs.push_back(mk(1,0,0,0, 64, 1,1,1, 4));
    vecs.push_back(mk(1,0,1,0,  1, 0,0,0, 5));
    vecs.push_back(mk(1,0,1,0, 63, 0,0,0, 5));
    vecs.push_back(mk(1,0,1,0,  1, 0,1,1, 5));
    vecs.push_back(mk(1,0,0,0,  1, 1,0,0, 6));
    vecs.push_back(mk(1,0,0,0, 64, 1,1,1, 6));
    // Forced retarget inside guard restarts it
    vecs.push_back(mk(1,0,1,0,  5, 0,0,0, 7));
    vecs.push_back(mk(1,0,1,1,  1, 1,0,0, 8));
    vecs.push_back(mk(1,0,1,1, 63, 1,0,0, 8));
    vecs.push_back(mk(1,0,1,1,  1, 1,1,1, 8));
    vecs.push_back(mk(1,0,0,1,  5, 1,1,1, 8));

    rst = 1'b1; link1 = 0; link2 = 0; force_en = 0; force_sel = 0;
    #2;
    chk_all("reset_async", 1, 0, 0, 0);
    tick(3);
    chk_all("reset_held", 1, 0, 0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      link1 = vecs[i].l1; link2 = vecs[i].l2;
      force_en = vecs[i].fe; force_sel = vecs[i].fs;
      tick(int'(vecs[i].n));
      chk_all($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_mux, vecs[i].e_led, vecs[i].e_cnt);
    end

    // Saturate switch_cnt with repeated forced retargets inside guard
    force_en = 1'b1;
    force_sel = 1'b0;
    tick(1);
    for (int k = 0; k < 260; k++) begin
      force_sel = ~force_sel;
      tick(1);
    end
    chk("sat_cnt", int'(switch_cnt), 255);
    chk("sat_sel", int'(sel), int'(force_sel));
    force_sel = ~force_sel;
    tick(1);
    chk("sat_hold_cnt", int'(switch_cnt), 255);
    chk("sat_hold_sel", int'(sel), int'(force_sel));
    chk("sat_hold_mux", int'(mux_en), 0);

    // Asynchronous reset mid-guard takes effect before the next edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all("rst_mid_guard", 1, 0, 0, 0);
    force_en = 1'b0;
    link1 = 1'b1;
    link2 = 1'b0;
    tick(2);
    chk_all("rst_hold", 1, 0, 0, 0);
    rst = 1'b0;

    // Reset mid-debounce discards partial progress
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(18);
    chk_all("deb_restart_pre", 1, 0, 0, 0);
    tick(1);
    chk_all("deb_restart_guard", 1, 0, 0, 1);
    tick(64);
    chk_all("deb_restart_active", 1, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
